// File: rtl/align_norm.sv
// Divisor normaliser for the iterative divider: shifts |b| left by the largest k
// with (|b|<<k) <= |a| and no bit lost, behind a start/ready/done handshake.
module align_norm #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             alrst_n,
  input  logic             start,
  input  logic             sgn,
  input  logic             abort,
  input  logic [WIDTH-1:0] ala,
  input  logic [WIDTH-1:0] alb,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic             div0,
  output logic [SHW-1:0]   shamt,
  output logic [WIDTH-1:0] shiftb,
  output logic [WIDTH-1:0] amag,
  output logic             qsign,
  output logic             asign
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_SCAN = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0] state;

  logic signed [WIDTH-1:0] a_p0;
  logic signed [WIDTH-1:0] b_p0;
  logic                    sgn_p0;

  logic [WIDTH-1:0] amag_p1;
  logic [WIDTH-1:0] bcur_p1;
  logic [SHW-1:0]   k_p1;
  logic             qs_p1;
  logic             as_p1;

  logic [WIDTH-1:0] amag_ld;
  logic [WIDTH-1:0] bmag_ld;
  logic             qs_ld;
  logic             as_ld;
  logic [WIDTH:0]   cand;
  logic             fit;

  // The most negative operand negates onto itself, which read unsigned is 2^(WIDTH-1).
  function automatic logic [WIDTH-1:0] mag_of(input logic signed [WIDTH-1:0] v,
                                               input logic s);
    if (s && v[WIDTH-1]) mag_of = $unsigned(-v);
    else                 mag_of = $unsigned(v);
  endfunction

  always_comb begin
    amag_ld = mag_of(a_p0, sgn_p0);
    bmag_ld = mag_of(b_p0, sgn_p0);
    qs_ld   = sgn_p0 & (a_p0[WIDTH-1] ^ b_p0[WIDTH-1]);
    as_ld   = sgn_p0 & a_p0[WIDTH-1];
    cand    = {bcur_p1, 1'b0};
    // The carry-out bit stops the scan before any divisor bit leaves the top.
    fit     = !cand[WIDTH] && (cand[WIDTH-1:0] <= amag_p1);
  end

  assign ready = (state == S_IDLE) || (state == S_DONE);
  assign busy  = (state == S_LOAD) || (state == S_SCAN);
  assign done  = (state == S_DONE);

  always_ff @(posedge clk or negedge alrst_n) begin
    if (!alrst_n) begin
      state   <= S_IDLE;
      a_p0    <= '0;
      b_p0    <= '0;
      sgn_p0  <= 1'b0;
      amag_p1 <= '0;
      bcur_p1 <= '0;
      k_p1    <= '0;
      qs_p1   <= 1'b0;
      as_p1   <= 1'b0;
      div0    <= 1'b0;
      shamt   <= '0;
      shiftb  <= '0;
      amag    <= '0;
      qsign   <= 1'b0;
      asign   <= 1'b0;
    end else if (abort) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          // capture stage (p0)
          if (start) begin
            a_p0   <= ala;
            b_p0   <= alb;
            sgn_p0 <= sgn;
            state  <= S_LOAD;
          end else begin
            state <= S_IDLE;
          end
        end
        S_LOAD: begin
          // magnitude stage (p1)
          amag_p1 <= amag_ld;
          qs_p1   <= qs_ld;
          as_p1   <= as_ld;
          if (bmag_ld == '0) begin
            div0   <= 1'b1;
            shamt  <= '0;
            shiftb <= '0;
            amag   <= amag_ld;
            qsign  <= 1'b0;
            asign  <= as_ld;
            state  <= S_DONE;
          end else begin
            bcur_p1 <= bmag_ld;
            k_p1    <= '0;
            state   <= S_SCAN;
          end
        end
        S_SCAN: begin
          // scan stage: one trial shift per cycle
          if (fit) begin
            bcur_p1 <= cand[WIDTH-1:0];
            k_p1    <= k_p1 + SHW'(1);
          end else begin
            div0   <= 1'b0;
            shamt  <= k_p1;
            shiftb <= bcur_p1;
            amag   <= amag_p1;
            qsign  <= qs_p1;
            asign  <= as_p1;
            state  <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/align_norm.md
Name: align_norm

Overview:
- Parametrised divisor normaliser for the iterative divider datapath.
- Left-shifts divisor b by the largest k such that (b<<k) <= a, with no bit lost off the top. Returns the shifted divisor, k, and the dividend magnitude.
- Unlike the fixed 32-bit aligner, it adds configurable width, a signed-operand mode, a start/ready/done handshake, a divide-by-zero flag and a synchronous abort.

Parameters:
- WIDTH, 32, operand width in bits; minimum 4.
- SHW, $clog2(WIDTH), width of the shift-amount output.

Ports:
- clk  input  1  rising-edge clock
- alrst_n  input  1  reset, asynchronous assert, active-low; clears all state
- start  input  1  request; accepted only when ready=1
- sgn  input  1  sampled with start; 1 = operands are two's complement
- abort  input  1  synchronous; returns FSM to IDLE next edge
- ala  input  WIDTH  dividend, sampled on accepting edge
- alb  input  WIDTH  divisor, sampled on accepting edge
- ready  output  1  high in IDLE and DONE
- busy  output  1  high in LOAD and SCAN
- done  output  1  one-cycle pulse in DONE
- div0  output  1  divisor magnitude was zero; valid with done, held
- shamt  output  SHW  final k; valid with done, held
- shiftb  output  WIDTH  |b|<<k; valid with done, held
- amag  output  WIDTH  |a|; valid with done, held
- qsign  output  1  sgn & (a[MSB]^b[MSB]); 0 when sgn=0 or div0
- asign  output  1  sgn & a[MSB]

Behaviour:
- Reset (alrst_n=0, asynchronous):
  - State IDLE; ready=1.
  - busy, done, div0, qsign, asign = 0.
  - shamt, shiftb, amag = 0.
  - Internal registers are cleared.
- FSM states: IDLE, LOAD, SCAN, DONE.
- IDLE/DONE with start=1: capture ala, alb, sgn; go to LOAD. DONE falls through after one cycle to IDLE when start=0. A start in DONE is accepted, so back-to-back operations are allowed.
- LOAD:
  - When sgn=1, take magnitudes by two's-complement negate if MSB=1. The most negative value gives 2^(WIDTH-1), held unsigned in WIDTH bits.
  - When sgn=0, operands pass through unchanged.
  - If |b|==0: div0=1, shamt=0, shiftb=0, qsign=0; go to DONE.
  - Otherwise load bcur=|b| and k=0; go to SCAN.
- SCAN, once per cycle:
  - cand = {bcur,1'b0}, computed in WIDTH+1 bits.
  - If cand[WIDTH]==0 and cand[WIDTH-1:0] <= amag: bcur<=cand and k<=k+1.
  - Else go to DONE with shiftb=bcur and shamt=k.
  - k never exceeds WIDTH-1; the overflow bit enforces this.
- DONE: done=1 for exactly one cycle. Result outputs hold until the next accepted start, abort, or reset.
- Latency, counting the accepting edge as edge 1:
  - Normal case: done is high after edge shamt+3.
  - div0 case: done is high after edge 2.
- start while busy=1 is ignored; no queueing.
- abort takes priority over all transitions:
  - Next edge goes to IDLE with done=0.
  - Result outputs keep their previous values.
  - abort in IDLE has no effect.
- Outputs are registered; no combinational path from inputs to outputs.
- Equality counts as fit: a==b gives shamt=0; a==2b gives shamt=1.

Test Plan:
- Unsigned, WIDTH=32: ala=100, alb=3, sgn=0 -> shamt=5, shiftb=96, amag=100, div0=0, done after edge 8.
- Signed: ala=0xFFFFFF9C (-100), alb=3, sgn=1 -> amag=100, shamt=5, shiftb=96, qsign=1, asign=1. Also ala=0x80000000, alb=1, sgn=1 -> amag=0x80000000, shamt=31, shiftb=0x80000000.
- Boundaries:
  - ala=0xFFFFFFFF, alb=1, sgn=0 -> shamt=31, shiftb=0x80000000; no overflow wrap.
  - ala=5, alb=7 -> shamt=0, shiftb=7, done after edge 3.
  - ala=8, alb=4 -> shamt=1, shiftb=8.
- Divide by zero: alb=0 (and alb=0 with sgn=1) -> div0=1, shamt=0, shiftb=0, qsign=0, done after edge 2. The next op with alb=1 clears div0.
- Control:
  - start pulsed during SCAN is ignored and the result is unchanged.
  - abort during SCAN -> IDLE next edge, no done pulse.
  - alrst_n low mid-SCAN (not clock-aligned) -> all outputs 0 and ready=1 immediately.
  - Back-to-back start in the DONE cycle is accepted.
- WIDTH=16 instance: ala=0xFFFF, alb=0x0003 -> shamt=14, shiftb=0xC000. Random unsigned/signed sweep against a reference model.
